// File: rtl/qos_channel_arbiter.sv
// Error-count driven selection of one active channel among N_CH redundant TS inputs.
// Build option: define QOS_HYSTERESIS_EN to apply cfg_hyst as the margin on periodic evaluations.
module qos_channel_arbiter #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned ERR_W = 8,
  parameter int unsigned TMR_W = 20,
  localparam int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N_CH-1:0]       valid_i,
  input  logic [N_CH*ERR_W-1:0] err_count_i,
  input  logic                  cfg_load_i,
  input  logic                  cfg_manual_i,
  input  logic [SEL_W-1:0]      cfg_manual_ch_i,
  input  logic [N_CH*SEL_W-1:0] cfg_priority_i,
  input  logic [TMR_W-1:0]      cfg_period_i,
  input  logic                  cfg_fallback_i,
  input  logic [ERR_W-1:0]      cfg_hyst_i,
  output logic [SEL_W-1:0]      sel_ch_o,
  output logic                  sel_en_o,
  output logic                  switch_pulse_o,
  output logic [TMR_W-1:0]      timer_o
);

  typedef enum logic [1:0] {StIdle, StConfig, StAuto, StManual} state_e;

  state_e                state_q, state_d;
  logic                  manual_q;
  logic [SEL_W-1:0]      manual_ch_q;
  logic [N_CH*SEL_W-1:0] prio_q;
  logic [TMR_W-1:0]      period_q;
  logic                  fallback_q;
  logic [TMR_W-1:0]      cnt_q, cnt_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic                  en_q, en_d;
  logic                  pulse_q, pulse_d;
  logic [ERR_W-1:0]      margin;

`ifdef QOS_HYSTERESIS_EN
  logic [ERR_W-1:0] hyst_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hyst_q <= '0;
    end else if (cfg_load_i) begin
      hyst_q <= cfg_hyst_i;
    end
  end

  assign margin = hyst_q;
`else
  logic unused_hyst;
  assign unused_hyst = ^cfg_hyst_i;
  assign margin      = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      manual_q    <= 1'b0;
      manual_ch_q <= '0;
      prio_q      <= '0;
      period_q    <= '0;
      fallback_q  <= 1'b0;
    end else if (cfg_load_i) begin
      manual_q    <= cfg_manual_i;
      manual_ch_q <= cfg_manual_ch_i;
      prio_q      <= cfg_priority_i;
      period_q    <= cfg_period_i;
      fallback_q  <= cfg_fallback_i;
    end
  end

  logic [ERR_W-1:0] err_arr [N_CH];
  logic [SEL_W-1:0] slot_ch, best_ch, winner_ch;
  logic [ERR_W-1:0] best_err, cur_err;
  logic             best_found, cur_valid, better, tie_take, eval_fire, eval_switch;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      err_arr[i] = err_count_i[i*ERR_W +: ERR_W];
    end
  end

  // Walk the priority list from slot 0; strict '<' keeps the lowest slot on ties.
  always_comb begin
    best_found = 1'b0;
    best_ch    = '0;
    best_err   = '0;
    slot_ch    = '0;
    for (int s = 0; s < N_CH; s++) begin
      slot_ch = prio_q[s*SEL_W +: SEL_W];
      if (32'(slot_ch) < N_CH && valid_i[slot_ch] &&
          (!best_found || err_arr[slot_ch] < best_err)) begin
        best_found = 1'b1;
        best_ch    = slot_ch;
        best_err   = err_arr[slot_ch];
      end
    end
  end

  assign cur_valid = valid_i[sel_q];
  assign cur_err   = err_arr[sel_q];
  assign winner_ch = (!fallback_q && cur_valid && best_found && best_err == cur_err) ?
                     sel_q : best_ch;
  // One extra bit so err + margin cannot wrap.
  assign better    = ({1'b0, best_err} + {1'b0, margin}) < {1'b0, cur_err};
  assign tie_take  = (margin == '0) && fallback_q && (best_err == cur_err);
  assign eval_fire = (period_q != '0) && (cnt_q == period_q - TMR_W'(1));
  assign eval_switch = best_found && (winner_ch != sel_q) && (better || tie_take);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    en_d    = en_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (cfg_load_i) begin
      state_d = StConfig;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StConfig: begin
          sel_d   = manual_q ? manual_ch_q : prio_q[SEL_W-1:0];
          en_d    = 1'b1;
          cnt_d   = '0;
          state_d = manual_q ? StManual : StAuto;
        end
        StAuto: begin
          if (!cur_valid) begin
            cnt_d = '0;
            if (best_found) begin
              sel_d = best_ch;
            end
          end else if (eval_fire) begin
            cnt_d = '0;
            if (eval_switch) begin
              sel_d = winner_ch;
            end
          end else begin
            cnt_d = cnt_q + TMR_W'(1);
          end
        end
        default: ;
      endcase
    end
    pulse_d = (sel_d != sel_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      sel_q   <= '0;
      en_q    <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sel_ch_o       = sel_q;
  assign sel_en_o       = en_q;
  assign switch_pulse_o = pulse_q;
  assign timer_o        = (en_q && state_q == StAuto) ? period_q : '0;

endmodule

// File: tb/tb_qos_channel_arbiter.sv
// Self-checking bench for qos_channel_arbiter: directed scenarios plus randomized run vs. a model.
module tb_qos_channel_arbiter;

  logic        clk = 1'b0;
  logic        rst, cfg_load, cfg_manual, cfg_fallback;
  logic [1:0]  cfg_manual_ch;
  logic [7:0]  cfg_priority, cfg_hyst;
  logic [19:0] cfg_period;
  logic [3:0]  valid;
  logic [31:0] err_count;
  logic [1:0]  sel_ch;
  logic        sel_en, switch_pulse;
  logic [19:0] timer;

  logic        w_rst, w_load;
  logic [7:0]  w_valid;
  logic [95:0] w_err;
  logic [2:0]  w_mch, w_sel;
  logic [23:0] w_prio;
  logic [19:0] w_period, w_timer;
  logic [11:0] w_hyst;
  logic        w_en, w_pulse;

  int n_pass = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  qos_channel_arbiter dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .err_count_i(err_count),
    .cfg_load_i(cfg_load), .cfg_manual_i(cfg_manual), .cfg_manual_ch_i(cfg_manual_ch),
    .cfg_priority_i(cfg_priority), .cfg_period_i(cfg_period), .cfg_fallback_i(cfg_fallback),
    .cfg_hyst_i(cfg_hyst), .sel_ch_o(sel_ch), .sel_en_o(sel_en),
    .switch_pulse_o(switch_pulse), .timer_o(timer)
  );

  qos_channel_arbiter #(.N_CH(8), .ERR_W(12), .TMR_W(20)) dut_wide (
    .clk_i(clk), .rst_i(w_rst), .valid_i(w_valid), .err_count_i(w_err),
    .cfg_load_i(w_load), .cfg_manual_i(1'b0), .cfg_manual_ch_i(w_mch),
    .cfg_priority_i(w_prio), .cfg_period_i(w_period), .cfg_fallback_i(1'b1),
    .cfg_hyst_i(w_hyst), .sel_ch_o(w_sel), .sel_en_o(w_en),
    .switch_pulse_o(w_pulse), .timer_o(w_timer)
  );

  // Reference model: 0 idle, 1 config, 2 auto, 3 manual.
  int          m_state = 0;
  int          m_cnt = 0;
  logic [1:0]  m_sel = 2'd0;
  logic        m_en = 1'b0;
  logic        m_pulse = 1'b0;
  logic        c_man = 1'b0, c_fb = 1'b0;
  logic [1:0]  c_mch = 2'd0;
  logic [7:0]  c_prio = 8'd0, c_hyst = 8'd0;
  logic [19:0] c_per = 20'd0;

  function automatic int m_err(int ch);
    return int'((err_count >> (8 * ch)) & 32'hFF);
  endfunction

  function automatic logic [19:0] m_timer();
    return (m_state == 2 && m_en) ? c_per : 20'd0;
  endfunction

  task automatic model_step();
    logic [1:0] nsel;
    int best, best_err, cur_err, margin, ch;
    nsel = m_sel;
    if (rst) begin
      m_state = 0; m_cnt = 0; m_en = 1'b0; nsel = 2'd0;
      c_man = 1'b0; c_mch = 2'd0; c_prio = 8'd0; c_per = 20'd0; c_fb = 1'b0; c_hyst = 8'd0;
    end else if (cfg_load) begin
      c_man = cfg_manual; c_mch = cfg_manual_ch; c_prio = cfg_priority;
      c_per = cfg_period; c_fb = cfg_fallback; c_hyst = cfg_hyst;
      m_state = 1; m_cnt = 0;
    end else if (m_state == 1) begin
      nsel = c_man ? c_mch : c_prio[1:0];
      m_en = 1'b1; m_cnt = 0;
      m_state = c_man ? 3 : 2;
    end else if (m_state == 2) begin
      best = -1; best_err = 0;
      for (int s = 0; s < 4; s++) begin
        ch = int'((c_prio >> (2 * s)) & 8'h3);
        if (valid[ch] && (best < 0 || m_err(ch) < best_err)) begin
          best = ch; best_err = m_err(ch);
        end
      end
      cur_err = m_err(int'(m_sel));
`ifdef QOS_HYSTERESIS_EN
      margin = int'(c_hyst);
`else
      margin = 0;
`endif
      if (!valid[m_sel]) begin
        m_cnt = 0;
        if (best >= 0) nsel = 2'(best);
      end else if (c_per != 0 && m_cnt == int'(c_per) - 1) begin
        m_cnt = 0;
        if (best >= 0 && 2'(best) != m_sel &&
            (best_err + margin < cur_err || (margin == 0 && c_fb && best_err == cur_err)))
          nsel = 2'(best);
      end else begin
        m_cnt++;
      end
    end
    m_pulse = rst ? 1'b0 : (nsel != m_sel);
    m_sel = nsel;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_config(input logic man, input logic [1:0] mch, input logic [7:0] pr,
                           input logic [19:0] per, input logic fb, input logic [7:0] hy);
    cfg_manual = man; cfg_manual_ch = mch; cfg_priority = pr;
    cfg_period = per; cfg_fallback = fb; cfg_hyst = hy;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_load = 1'b1; cfg_manual = 1'b1; cfg_manual_ch = 2'd3;
    cfg_priority = 8'hFF; cfg_period = 20'd7; cfg_fallback = 1'b0; cfg_hyst = 8'd0;
    valid = 4'hF; err_count = 32'h09090909;
    w_rst = 1'b1; w_load = 1'b0; w_valid = 8'hFF; w_err = '0; w_mch = 3'd0;
    w_prio = '0; w_period = '0; w_hyst = '0;
    tick(); tick();
    n_checks++; if (sel_ch !== 2'd0) $display("FAIL rst_sel: got %0d want 0", sel_ch); else n_pass++;
    n_checks++; if (sel_en !== 1'b0) $display("FAIL rst_en: got %0d want 0", sel_en); else n_pass++;
    n_checks++; if (switch_pulse !== 1'b0) $display("FAIL rst_pulse: got %0d want 0", switch_pulse); else n_pass++;
    n_checks++; if (timer !== 20'd0) $display("FAIL rst_timer: got %0d want 0", timer); else n_pass++;
    rst = 1'b0; cfg_load = 1'b0; w_rst = 1'b0;
    tick(); tick();
    // A cfg_load held during reset must not have been latched.
    n_checks++; if (sel_en !== 1'b0 || sel_ch !== 2'd0)
      $display("FAIL rst_over_load: got en=%0d sel=%0d want en=0 sel=0", sel_en, sel_ch);
    else n_pass++;
  endtask

  task automatic test_config_load();
    valid = 4'hF; err_count = 32'h09090909;
    do_config(1'b0, 2'd0, 8'hD2, 20'd10, 1'b1, 8'd2);
    n_checks++; if (sel_ch !== 2'd2) $display("FAIL cfg_sel: got %0d want 2", sel_ch); else n_pass++;
    n_checks++; if (sel_en !== 1'b1) $display("FAIL cfg_en: got %0d want 1", sel_en); else n_pass++;
    n_checks++; if (switch_pulse !== 1'b1) $display("FAIL cfg_pulse: got %0d want 1", switch_pulse); else n_pass++;
    n_checks++; if (timer !== 20'd10) $display("FAIL cfg_timer: got %0d want 10", timer); else n_pass++;
    tick();
    n_checks++; if (switch_pulse !== 1'b0) $display("FAIL cfg_pulse_drop: got %0d want 0", switch_pulse); else n_pass++;
  endtask

  task automatic test_periodic_eval();
    logic [1:0] exp_sel;
    err_count = {8'd9, 8'd9, 8'd9, 8'd5};
    do_config(1'b0, 2'd0, 8'hD2, 20'd10, 1'b1, 8'd2);
    repeat (9) tick();
    n_checks++; if (sel_ch !== 2'd2) $display("FAIL eval_early: got %0d want 2", sel_ch); else n_pass++;
    tick();
    n_checks++; if (sel_ch !== 2'd0 || switch_pulse !== 1'b1)
      $display("FAIL eval_switch: got sel=%0d pulse=%0d want sel=0 pulse=1", sel_ch, switch_pulse);
    else n_pass++;
    err_count = {8'd9, 8'd9, 8'd9, 8'd8};
    do_config(1'b0, 2'd0, 8'hD2, 20'd10, 1'b1, 8'd2);
    repeat (10) tick();
`ifdef QOS_HYSTERESIS_EN
    exp_sel = 2'd2;
`else
    exp_sel = 2'd0;
`endif
    n_checks++; if (sel_ch !== exp_sel) $display("FAIL eval_hyst: got %0d want %0d", sel_ch, exp_sel); else n_pass++;
  endtask

  task automatic test_failover();
    err_count = {8'd9, 8'd7, 8'd3, 8'd6};
    do_config(1'b0, 2'd0, 8'hE1, 20'd10, 1'b1, 8'd2);
    n_checks++; if (sel_ch !== 2'd1) $display("FAIL fo_start: got %0d want 1", sel_ch); else n_pass++;
    repeat (3) tick();
    valid = 4'b1101;
    tick();
    valid = 4'hF;
    n_checks++; if (sel_ch !== 2'd0 || switch_pulse !== 1'b1)
      $display("FAIL fo_switch: got sel=%0d pulse=%0d want sel=0 pulse=1", sel_ch, switch_pulse);
    else n_pass++;
    repeat (9) tick();
    n_checks++; if (sel_ch !== 2'd0) $display("FAIL fo_cnt_clear: got %0d want 0", sel_ch); else n_pass++;
    tick();
    n_checks++; if (sel_ch !== 2'd1) $display("FAIL fo_eval_back: got %0d want 1", sel_ch); else n_pass++;
  endtask

  task automatic test_tie();
    int pulses;
    err_count = 32'h04040404;
    do_config(1'b0, 2'd0, 8'hD2, 20'd4, 1'b1, 8'd0);
    valid = 4'b1011;
    tick();
    valid = 4'hF;
    n_checks++; if (sel_ch !== 2'd0) $display("FAIL tie_fo: got %0d want 0", sel_ch); else n_pass++;
    repeat (3) tick();
    n_checks++; if (sel_ch !== 2'd0) $display("FAIL tie_early: got %0d want 0", sel_ch); else n_pass++;
    tick();
    n_checks++; if (sel_ch !== 2'd2 || switch_pulse !== 1'b1)
      $display("FAIL tie_fb1: got sel=%0d pulse=%0d want sel=2 pulse=1", sel_ch, switch_pulse);
    else n_pass++;
    do_config(1'b0, 2'd0, 8'hD2, 20'd4, 1'b0, 8'd0);
    valid = 4'b1011;
    tick();
    valid = 4'hF;
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (switch_pulse === 1'b1) pulses++;
    end
    n_checks++; if (sel_ch !== 2'd0 || pulses != 0)
      $display("FAIL tie_fb0: got sel=%0d pulses=%0d want sel=0 pulses=0", sel_ch, pulses);
    else n_pass++;
  endtask

  task automatic test_manual();
    int bad;
    valid = 4'h0; err_count = {8'd255, 8'd0, 8'd0, 8'd0};
    do_config(1'b1, 2'd3, 8'hD2, 20'd5, 1'b0, 8'd0);
    n_checks++; if (sel_ch !== 2'd3 || switch_pulse !== 1'b1 || sel_en !== 1'b1)
      $display("FAIL man_load: got sel=%0d pulse=%0d en=%0d want 3 1 1", sel_ch, switch_pulse, sel_en);
    else n_pass++;
    n_checks++; if (timer !== 20'd0) $display("FAIL man_timer: got %0d want 0", timer); else n_pass++;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      valid = 4'($urandom);
      err_count[7:0] = 8'($urandom);
      tick();
      if (sel_ch !== 2'd3 || switch_pulse !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL man_hold: got %0d bad cycles want 0", bad); else n_pass++;
    valid = 4'hF; err_count = {8'd9, 8'd9, 8'd9, 8'd1};
    do_config(1'b0, 2'd0, 8'hD2, 20'd3, 1'b1, 8'd2);
    tick(); tick();
    cfg_manual = 1'b1; cfg_manual_ch = 2'd2; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    n_checks++; if (sel_ch !== 2'd2 || switch_pulse !== 1'b0)
      $display("FAIL load_vs_eval: got sel=%0d pulse=%0d want sel=2 pulse=0", sel_ch, switch_pulse);
    else n_pass++;
    tick();
    n_checks++; if (sel_ch !== 2'd2 || switch_pulse !== 1'b0 || timer !== 20'd0)
      $display("FAIL load_vs_eval_cfg: got sel=%0d pulse=%0d timer=%0d want 2 0 0",
               sel_ch, switch_pulse, timer);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      rst = (i == 250) || ($urandom_range(0, 199) == 0);
      cfg_load = (i == 0) || (i == 250) || ($urandom_range(0, 59) == 0);
      if (cfg_load) begin
        cfg_manual = ($urandom_range(0, 3) == 0);
        cfg_manual_ch = 2'($urandom_range(0, 3));
        cfg_priority = 8'($urandom);
        cfg_period = 20'($urandom_range(0, 6));
        cfg_fallback = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0: cfg_hyst = 8'd0;
          1: cfg_hyst = 8'd1;
          2: cfg_hyst = 8'd2;
          default: cfg_hyst = 8'd255;
        endcase
      end
      valid = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
      if ($urandom_range(0, 9) == 0) begin
        for (int c = 0; c < 4; c++)
          err_count[8*c +: 8] = ($urandom_range(0, 15) == 0) ? 8'd255 : 8'($urandom_range(0, 12));
      end
      tick();
      n_checks++; if (sel_ch !== m_sel) $display("FAIL rnd_sel[%0d]: got %0d want %0d", i, sel_ch, m_sel); else n_pass++;
      n_checks++; if (sel_en !== m_en) $display("FAIL rnd_en[%0d]: got %0d want %0d", i, sel_en, m_en); else n_pass++;
      n_checks++; if (switch_pulse !== m_pulse)
        $display("FAIL rnd_pulse[%0d]: got %0d want %0d", i, switch_pulse, m_pulse);
      else n_pass++;
      n_checks++; if (timer !== m_timer())
        $display("FAIL rnd_timer[%0d]: got %0d want %0d", i, timer, m_timer());
      else n_pass++;
    end
    rst = 1'b0; cfg_load = 1'b0;
  endtask

  task automatic test_wide();
    int pulses;
    for (int s = 0; s < 8; s++) w_prio[3*s +: 3] = 3'(7 - s);
    for (int c = 0; c < 8; c++) w_err[12*c +: 12] = 12'(50 + c);
    w_err[12*7 +: 12] = 12'd100;
    w_valid = 8'hFF; w_period = 20'd0;
    w_load = 1'b1;
    tick();
    w_load = 1'b0;
    tick();
    n_checks++; if (w_sel !== 3'd7 || w_en !== 1'b1)
      $display("FAIL wide_cfg: got sel=%0d en=%0d want sel=7 en=1", w_sel, w_en);
    else n_pass++;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (w_pulse === 1'b1) pulses++;
    end
    n_checks++; if (w_sel !== 3'd7 || pulses != 0 || w_timer !== 20'd0)
      $display("FAIL wide_no_eval: got sel=%0d pulses=%0d timer=%0d want 7 0 0", w_sel, pulses, w_timer);
    else n_pass++;
    w_err[12*3 +: 12] = 12'd5;
    w_valid = 8'h7F;
    tick();
    w_valid = 8'hFF;
    n_checks++; if (w_sel !== 3'd3 || w_pulse !== 1'b1)
      $display("FAIL wide_failover: got sel=%0d pulse=%0d want sel=3 pulse=1", w_sel, w_pulse);
    else n_pass++;
    repeat (20) tick();
    n_checks++; if (w_sel !== 3'd3) $display("FAIL wide_hold: got %0d want 3", w_sel); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_config_load();
    test_periodic_eval();
    test_failover();
    test_tie();
    test_manual();
    test_random();
    test_wide();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/qos_channel_arbiter.md
QOS_CHANNEL_ARBITER -- requirements
Module: qos_channel_arbiter

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, meaning the number of TS input channels (legal 2..8).
REQ-002 The block SHALL have parameter ERR_W, default 8, meaning the width of each channel's error counter.
REQ-003 The block SHALL have parameter TMR_W, default 20, meaning the width of the evaluation-period counter; derived SEL_W = clog2(N_CH).
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: port clk  input  1  rising-edge clock.
REQ-005 Port rst  input  1  synchronous active-high reset.
REQ-006 Port valid  input  N_CH  per-channel signal present; bit i = channel i.
REQ-007 Port err_count  input  N_CH*ERR_W  packed error counters; channel i at bits [i*ERR_W +: ERR_W].
REQ-008 Port cfg_load  input  1  single-cycle pulse; latch all cfg_* inputs.
REQ-009 Port cfg_manual  input  1  1 = manual mode, 0 = auto mode.
REQ-010 Port cfg_manual_ch  input  SEL_W  channel forced in manual mode.
REQ-011 Port cfg_priority  input  N_CH*SEL_W  priority list; slot 0 (LSBs) = highest priority.
REQ-012 Port cfg_period  input  TMR_W  evaluation period in cycles; 0 = periodic evaluation off.
REQ-013 Port cfg_fallback  input  1  1 = on error-count tie prefer higher priority; 0 = on tie keep current channel.
REQ-014 Port cfg_hyst  input  ERR_W  switch hysteresis margin.
REQ-015 Port sel_ch  output  SEL_W  active channel to mux.
REQ-016 Port sel_en  output  1  mux enable.
REQ-017 Port switch_pulse  output  1  one-cycle pulse on every sel_ch change.
REQ-018 Port timer  output  TMR_W  latched cfg_period while sel_en=1 and state AUTO; else 0.

Function
REQ-019 States SHALL be IDLE, CONFIG, AUTO, MANUAL; IDLE->CONFIG on cfg_load; CONFIG->MANUAL if latched manual else AUTO, after exactly one cycle; AUTO/MANUAL->CONFIG on cfg_load.
REQ-020 In CONFIG the block SHALL set sel_en=1 and load sel_ch with manual_ch (manual) or priority slot 0 (auto), visible the cycle after CONFIG.
REQ-021 Period counter SHALL clear in CONFIG and on match, increment in AUTO, and fire an evaluation when counter == period-1 and period != 0.
REQ-022 Evaluation SHALL consider only channels with valid=1, selecting minimum err_count; ties resolved by cfg_fallback (1: lowest priority slot wins; 0: current channel wins if tied, else lowest slot).
REQ-023 A switch from an evaluation SHALL occur only if candidate err + hyst < current err (ERR_W+1-bit compare, no overflow); sel_ch updates one cycle after the evaluation cycle.
REQ-024 In AUTO, valid[sel_ch] low for one cycle SHALL cause immediate failover to the evaluation winner next cycle, ignoring hysteresis and the period counter, and SHALL clear the counter.
REQ-025 If no channel is valid, sel_ch SHALL hold its value; no switch_pulse.
REQ-026 In MANUAL, sel_ch SHALL stay fixed regardless of valid or err_count.
REQ-027 switch_pulse SHALL assert exactly in the cycle sel_ch takes a new value, including the CONFIG load if the value differs.
REQ-028 cfg_load coincident with an evaluation or failover SHALL take precedence; the evaluation is discarded.
REQ-029 Duplicate entries in cfg_priority SHALL be tolerated; a channel absent from the list is never selected in AUTO.

Reset
REQ-030 On rst: state=IDLE, sel_ch=0, sel_en=0, switch_pulse=0, timer=0, counter=0, all latched config=0.
REQ-031 rst asserted mid-operation SHALL override cfg_load and any pending evaluation in the same cycle.

Configuration
REQ-032 Macro QOS_HYSTERESIS_EN defined: REQ-023 hysteresis applies using cfg_hyst.
REQ-033 Macro QOS_HYSTERESIS_EN undefined: cfg_hyst is ignored, margin = 0, switch when candidate err < current err (or tie rule of REQ-022).

Verification
REQ-034 Reset, cfg_load with manual=0, priority {3,2,1,0}=slots{0..3} as 2,0,1,3 -> sel_ch=2, sel_en=1, switch_pulse=1 one cycle.
REQ-035 AUTO, period=10, errs ch0..3 = 5,9,9,9, current ch2, hyst=2 -> sel_ch=0 at cycle 11 after CONFIG exit; errs 8,9,9,9 with hyst=2 -> no switch.
REQ-036 AUTO, current ch1, valid[1] drops for one cycle -> sel_ch = min-err valid channel next cycle, counter cleared.
REQ-037 Tie all errs=4, fallback=1 -> slot-0 channel; fallback=0 -> current channel kept, no switch_pulse.
REQ-038 MANUAL ch3, all valid=0 and err ch3=255 -> sel_ch stays 3; cfg_load in evaluation cycle -> CONFIG wins.
REQ-039 N_CH=8, ERR_W=12 build, period=0 -> no periodic switch, failover still operates.
